// File: rtl/data_island_packetizer_pkg.sv
// Shared definitions for the data-island packetizer.
// The package holds the BCH generator constant, the packet geometry, the state
// enum, and the subpacket bundle type used by the interface and the datapath.
package data_island_packetizer_pkg;

    // BCH generator G(x) = 1 + x^6 + x^7 + x^8 in right-shift (LSB-first) form.
    localparam logic [7:0] BchPoly = 8'h83;

    localparam int unsigned NumSlices = 32;
    localparam int unsigned HdrWidth  = 24;
    localparam int unsigned SubWidth  = 56;
    localparam int unsigned NumSub    = 4;

    localparam logic [4:0] LastSlice = 5'(NumSlices - 1);
    // Header data is emitted 1 bit per slice; subpacket data 2 bits per slice.
    localparam logic [4:0] HdrSlices = 5'(HdrWidth);
    localparam logic [4:0] SubSlices = 5'(SubWidth / 2);

    typedef logic [NumSub-1:0][SubWidth-1:0] sub_blk_t;

    typedef enum logic {
        StIdle,
        StSend
    } state_t;

endpackage

// File: rtl/data_island_packetizer_if.sv
// Packet request / slice output bundle for the data-island packetizer.
//   start, header, sub : request side, sampled only when start && ready
//   ready              : packetizer can accept a packet this cycle
//   packet_valid/last  : packet_data carries a slice / the slice is number 31
//   packet_data        : 9-bit data-island slice
// master = requester, slave = packetizer.
interface data_island_packetizer_if;
    import data_island_packetizer_pkg::*;

    logic                start;
    logic                ready;
    logic [HdrWidth-1:0] header;
    sub_blk_t            sub;
    logic                packet_valid;
    logic                packet_last;
    logic [8:0]          packet_data;

    modport master (
        output start, header, sub,
        input  ready, packet_valid, packet_last, packet_data
    );

    modport slave (
        input  start, header, sub,
        output ready, packet_valid, packet_last, packet_data
    );

endinterface

// File: rtl/bch_ecc_step.sv
// Combinational BCH LFSR advance by Bits data bits (1 or 2), LSB first.
//   ecc_in  : current remainder
//   data_in : data bits, data_in[0] is processed first
//   ecc_out : remainder after all Bits steps
module bch_ecc_step
    import data_island_packetizer_pkg::*;
#(
    parameter int unsigned Bits = 1
) (
    input  logic [7:0]      ecc_in,
    input  logic [Bits-1:0] data_in,
    output logic [7:0]      ecc_out
);

    always_comb begin
        logic [7:0] e;
        logic       fb;
        e = ecc_in;
        for (int unsigned b = 0; b < Bits; b++) begin
            fb = e[0] ^ data_in[b];
            e  = (e >> 1) ^ (fb ? BchPoly : 8'h00);
        end
        ecc_out = e;
    end

endmodule

// File: rtl/data_island_packetizer.sv
// Data-island packetizer: latches a 24-bit header and four 56-bit subpackets on
// accept and emits them as 32 registered 9-bit slices, appending BCH ECC bytes
// that are computed serially while the data bits go out.
//   clk_pixel : pixel clock
//   reset     : asynchronous, active-high
//   bus       : request/slice bundle (slave side)
// ZERO_WHEN_IDLE: 1 = packet_data reads 0 while packet_valid is low, 0 = hold.
module data_island_packetizer
    import data_island_packetizer_pkg::*;
#(
    parameter logic ZERO_WHEN_IDLE = 1'b1
) (
    input logic                      clk_pixel,
    input logic                      reset,
    data_island_packetizer_if.slave  bus
);

    state_t                       state_q, state_d;
    logic [4:0]                   count_q, count_d;
    logic [HdrWidth-1:0]          hdr_q, hdr_d;
    sub_blk_t                     sub_q, sub_d;
    logic [7:0]                   hdr_ecc_q, hdr_ecc_d;
    logic [NumSub-1:0][7:0]       sub_ecc_q, sub_ecc_d;
    logic                         valid_q, valid_d;
    logic                         last_q, last_d;
    logic [8:0]                   data_q, data_d;

    logic                         ready;
    logic                         accept;
    logic [4:0]                   next_slice;
    logic [4:0]                   hdr_idx;
    logic [5:0]                   sub_idx;
    logic [HdrWidth-1:0]          hdr_src;
    sub_blk_t                     sub_src;
    logic [7:0]                   hdr_ecc_src;
    logic [NumSub-1:0][7:0]       sub_ecc_src;
    logic                         hdr_bit;
    logic [NumSub-1:0][1:0]       sub_bits;
    logic [7:0]                   hdr_ecc_nxt;
    logic [NumSub-1:0][7:0]       sub_ecc_nxt;

    // On accept, slice 0 is built straight from the inputs so it is registered on
    // the accept edge; afterwards everything comes from the latched copy.
    always_comb begin
        ready       = (state_q == StIdle) || (count_q == LastSlice);
        accept      = bus.start && ready;
        hdr_src     = accept ? bus.header : hdr_q;
        sub_src     = accept ? bus.sub : sub_q;
        hdr_ecc_src = accept ? 8'h00 : hdr_ecc_q;
        sub_ecc_src = accept ? '0 : sub_ecc_q;
        next_slice  = accept ? 5'd0 : count_q + 5'd1;
        // Clamp indices during ECC slices; the data bits are unused there.
        hdr_idx     = (next_slice < HdrSlices) ? next_slice : 5'd0;
        sub_idx     = (next_slice < SubSlices) ? {next_slice, 1'b0} : 6'd0;
        hdr_bit     = hdr_src[hdr_idx];
        for (int k = 0; k < int'(NumSub); k++) begin
            sub_bits[k] = sub_src[k][sub_idx +: 2];
        end
    end

    bch_ecc_step #(
        .Bits (1)
    ) u_hdr_step (
        .ecc_in  (hdr_ecc_src),
        .data_in (hdr_bit),
        .ecc_out (hdr_ecc_nxt)
    );

    for (genvar g = 0; g < int'(NumSub); g++) begin : g_sub_step
        bch_ecc_step #(
            .Bits (2)
        ) u_sub_step (
            .ecc_in  (sub_ecc_src[g]),
            .data_in (sub_bits[g]),
            .ecc_out (sub_ecc_nxt[g])
        );
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hdr_d     = hdr_q;
        sub_d     = sub_q;
        hdr_ecc_d = hdr_ecc_q;
        sub_ecc_d = sub_ecc_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        data_d    = ZERO_WHEN_IDLE ? 9'h000 : data_q;

        if (accept) begin
            hdr_d = bus.header;
            sub_d = bus.sub;
        end

        if (accept || (state_q == StSend && count_q != LastSlice)) begin
            state_d = StSend;
            count_d = next_slice;
            valid_d = 1'b1;
            last_d  = (next_slice == LastSlice);

            // Header: data bits 0..23, then the final remainder bits 0..7.
            if (next_slice < HdrSlices) begin
                data_d[0] = hdr_bit;
                hdr_ecc_d = hdr_ecc_nxt;
            end else begin
                data_d[0] = hdr_ecc_src[next_slice[2:0]];
            end

            // Subpackets: bit pairs 0..55, then remainder pairs at slices 28..31.
            for (int k = 0; k < int'(NumSub); k++) begin
                if (next_slice < SubSlices) begin
                    data_d[1+k]  = sub_bits[k][0];
                    data_d[5+k]  = sub_bits[k][1];
                    sub_ecc_d[k] = sub_ecc_nxt[k];
                end else begin
                    data_d[1+k] = sub_ecc_src[k][{next_slice[1:0], 1'b0}];
                    data_d[5+k] = sub_ecc_src[k][{next_slice[1:0], 1'b1}];
                end
            end
        end else begin
            state_d = StIdle;
            count_d = 5'd0;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= 5'd0;
            hdr_q     <= '0;
            sub_q     <= '0;
            hdr_ecc_q <= 8'h00;
            sub_ecc_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= 9'h000;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hdr_q     <= hdr_d;
            sub_q     <= sub_d;
            hdr_ecc_q <= hdr_ecc_d;
            sub_ecc_q <= sub_ecc_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            data_q    <= data_d;
        end
    end

    assign bus.ready        = ready;
    assign bus.packet_valid = valid_q;
    assign bus.packet_last  = last_q;
    assign bus.packet_data  = data_q;

endmodule

// File: tb/tb_data_island_packetizer.sv
// Self-checking bench for data_island_packetizer: directed and random packets
// compared slice by slice against a block-level BCH reference model.
module tb_data_island_packetizer;
    import data_island_packetizer_pkg::*;

    logic        clk_pixel = 1'b0;
    logic        reset;
    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [8:0]  seen [32];
    logic [7:0]  ecc83 = 8'h83;

    data_island_packetizer_if bus ();

    data_island_packetizer #(
        .ZERO_WHEN_IDLE (1'b1)
    ) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    // BCH remainder of the first n bits of d, LSB first.
    function automatic logic [7:0] bch(input logic [63:0] d, input int n);
        logic [7:0] e;
        logic       fb;
        e = 8'h00;
        for (int b = 0; b < n; b++) begin
            fb = e[0] ^ d[b];
            e  = (e >> 1) ^ (fb ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    // Expected 9-bit word for slice i, built from the full ECC-extended blocks.
    function automatic logic [8:0] slice_word(input logic [23:0] h, input sub_blk_t s,
                                              input int i);
        logic [31:0] hb;
        logic [63:0] sb;
        logic [8:0]  w;
        hb   = {bch({40'd0, h}, 24), h};
        w[0] = hb[i];
        for (int k = 0; k < 4; k++) begin
            sb       = {bch({8'd0, s[k]}, 56), s[k]};
            w[1+k]   = sb[2*i];
            w[5+k]   = sb[2*i+1];
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic go(input logic [23:0] h, input sub_blk_t s);
        bus.header = h;
        bus.sub    = s;
        bus.start  = 1'b1;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk_pixel);
        check({tag, " idle valid"}, 32'(bus.packet_valid), 32'd0);
        check({tag, " idle last"}, 32'(bus.packet_last), 32'd0);
        check({tag, " idle ready"}, 32'(bus.ready), 32'd1);
        check({tag, " idle data"}, 32'(bus.packet_data), 32'd0);
    endtask

    // Checks the 32 slices of the packet accepted on the coming edge.
    // poke_at: slice at which a spurious start with other inputs is raised.
    // abort_at: slice after which checking stops (reset test).
    task automatic expect_pkt(input logic [23:0] h, input sub_blk_t s, input string tag,
                              input bit keep_start, input int poke_at, input int abort_at);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk_pixel);
            seen[i] = bus.packet_data;
            check($sformatf("%s valid s%0d", tag, i), 32'(bus.packet_valid), 32'd1);
            check($sformatf("%s last s%0d", tag, i), 32'(bus.packet_last), 32'(i == 31));
            check($sformatf("%s ready s%0d", tag, i), 32'(bus.ready), 32'(i == 31));
            check($sformatf("%s data s%0d", tag, i), 32'(bus.packet_data),
                  32'(slice_word(h, s, i)));
            if (i == abort_at) return;
            if (i == 0 && !keep_start) bus.start = 1'b0;
            if (i == poke_at) begin
                bus.start  = 1'b1;
                bus.header = ~h;
                bus.sub[0] = ~s[0];
            end
            if (i == poke_at + 1) bus.start = 1'b0;
        end
    endtask

    initial begin
        logic [23:0] h [3];
        sub_blk_t    s [3];
        sub_blk_t    sv;

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.header = '0;
        bus.sub    = '0;
        #1;
        check("reset valid", 32'(bus.packet_valid), 32'd0);
        check("reset last", 32'(bus.packet_last), 32'd0);
        check("reset ready", 32'(bus.ready), 32'd1);
        check("reset data", 32'(bus.packet_data), 32'd0);
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        reset = 1'b0;
        idle_check("post reset");

        // All-zero packet.
        go(24'h0, '0);
        expect_pkt(24'h0, '0, "zero", 1'b0, 99, 99);
        for (int i = 0; i < 32; i++) check($sformatf("zero word s%0d", i), 32'(seen[i]), 32'd0);
        idle_check("zero");

        // Header MSB only: header ECC is 8'h83.
        go(24'h800000, '0);
        expect_pkt(24'h800000, '0, "hdr msb", 1'b0, 99, 99);
        for (int j = 0; j < 8; j++)
            check($sformatf("hdr ecc bit%0d", j), 32'(seen[24+j][0]), 32'(ecc83[j]));
        idle_check("hdr msb");

        // Subpacket 2 MSB only.
        sv    = '0;
        sv[2] = 56'h80_0000_0000_0000;
        go(24'h0, sv);
        expect_pkt(24'h0, sv, "sub2 msb", 1'b0, 99, 99);
        check("sub2 s27 d7", 32'(seen[27][7]), 32'd1);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("sub2 ecc even%0d", j), 32'(seen[28+j][3]), 32'(ecc83[2*j]));
            check($sformatf("sub2 ecc odd%0d", j), 32'(seen[28+j][7]), 32'(ecc83[2*j+1]));
        end
        idle_check("sub2 msb");

        // Start held for three random packets: gapless 96 slices.
        for (int p = 0; p < 3; p++) begin
            h[p] = 24'($urandom);
            for (int k = 0; k < 4; k++) s[p][k] = 56'({$urandom, $urandom});
        end
        go(h[0], s[0]);
        for (int p = 0; p < 3; p++) begin
            expect_pkt(h[p], s[p], $sformatf("chain%0d", p), 1'b1, 99, 99);
            if (p < 2) go(h[p+1], s[p+1]);
            else bus.start = 1'b0;
        end
        idle_check("chain");

        // Reset at slice 10, then a fresh packet.
        go(h[0], s[1]);
        expect_pkt(h[0], s[1], "pre abort", 1'b0, 99, 10);
        reset = 1'b1;
        #1;
        check("abort valid", 32'(bus.packet_valid), 32'd0);
        check("abort ready", 32'(bus.ready), 32'd1);
        check("abort last", 32'(bus.packet_last), 32'd0);
        check("abort data", 32'(bus.packet_data), 32'd0);
        @(negedge clk_pixel);
        reset = 1'b0;
        go(h[2], s[0]);
        expect_pkt(h[2], s[0], "post abort", 1'b0, 99, 99);
        idle_check("post abort");

        // Start while busy is ignored; mid-packet input changes have no effect.
        go(h[1], s[2]);
        expect_pkt(h[1], s[2], "poke", 1'b0, 5, 99);
        idle_check("poke");

        // A few more random packets with gaps.
        for (int p = 0; p < 4; p++) begin
            h[0] = 24'($urandom);
            for (int k = 0; k < 4; k++) s[0][k] = 56'({$urandom, $urandom});
            go(h[0], s[0]);
            expect_pkt(h[0], s[0], $sformatf("rand%0d", p), 1'b0, 99, 99);
            idle_check($sformatf("rand%0d", p));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_island_packetizer.md
DATA_ISLAND_PACKETIZER -- requirements
Module: data_island_packetizer

Interface
REQ-001 SHALL have parameter: ZERO_WHEN_IDLE, default 1'b1, drives packet_data to 0 whenever packet_valid is low (0 = hold the last driven value).
REQ-002 SHALL have ports (clock and reset first):
- clk_pixel  input  1  pixel clock; sole clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to accept header/sub this cycle.
- ready  output  1  block can accept a packet this cycle.
- header  input  24  packet header HB0..HB2; HB0 in [7:0].
- sub  input  4x56  subpackets 0..3; PB0 of each in [7:0].
- packet_valid  output  1  packet_data carries a packet bit slice.
- packet_last  output  1  marks slice 31.
- packet_data  output  9  per-cycle data-island bits (see REQ-008).
REQ-003 SHALL use one clock and asynchronous, active-high reset; all state resets asynchronously on reset high.

Function
REQ-004 SHALL accept a packet when start && ready on a clk_pixel edge, latching header and all four sub words; start while ready is low SHALL be ignored without side effects.
REQ-005 SHALL assert ready in IDLE, and in SEND only when the slice counter equals 31.
REQ-006 SHALL implement states IDLE and SEND:
- IDLE -> SEND on accept.
- SEND at count 31 -> SEND with count 0 if accept, else IDLE.
- Count increments by 1 per cycle in SEND.
REQ-007 SHALL present slice 0 with packet_valid=1 in the cycle after accept; slices 0..31 on 32 consecutive cycles. Back-to-back accepts SHALL produce gapless 64-cycle output.
REQ-008 SHALL map slice i (0..31), with all outputs registered:
- packet_data[0] = header-block bit i.
- packet_data[1+k] = subpacket-k block bit 2i, for k=0..3.
- packet_data[5+k] = subpacket-k block bit 2i+1, for k=0..3.
REQ-009 SHALL define the header block as 24 data bits followed by header ECC[7:0] (bits 24..31). Each subpacket block SHALL be 56 data bits followed by its ECC[7:0] (bits 56..63).
REQ-010 SHALL compute each ECC as BCH with G(x)=1+x^6+x^7+x^8:
- Data bits are processed LSB first from an initial value of 0.
- Per bit: fb = ecc[0] ^ bit; ecc = (ecc >> 1) ^ (fb ? 8'h83 : 0).
REQ-011 SHALL compute ECC serially during emission:
- Header: 1 bit per slice, slices 0..23.
- Subpackets: 2 bits per slice (bit 2i, then bit 2i+1), slices 0..27.
- ECC emission SHALL use the final value.
- ECC registers SHALL clear on every accept.
REQ-012 SHALL assert packet_last only with slice 31.
REQ-013 SHALL leave header/sub unsampled except at accept; input changes mid-packet SHALL NOT affect output.

Reset
REQ-014 SHALL on reset:
- state=IDLE, count=0, ECC registers=0, latched data=0.
- ready=1, packet_valid=0, packet_last=0, packet_data=0.
REQ-015 SHALL abort any in-progress packet on reset, with packet_valid low from the reset assertion onward; the first accept after release SHALL produce a complete fresh packet.

Structure
REQ-016 SHALL place in a shared package:
- BCH generator constant 8'h83.
- Packet slice count 32.
- Header/subpacket data widths 24/56.
- Subpacket count 4.
- The state enum.
REQ-017 SHALL use one sub-module, bch_ecc_step, that applies 1 or 2 LFSR bit-steps combinationally. It SHALL be instantiated once for the header and once per subpacket.

Verification
REQ-018 SHALL verify: header=0, sub=all 0, start pulse -> 32 slices with packet_data=9'h000, packet_valid high 32 cycles, packet_last on the 32nd.
REQ-019 SHALL verify: header=24'h800000, sub=0 -> packet_data[0] on slices 24..31 = 1,1,0,0,0,0,0,1 (ECC 8'h83).
REQ-020 SHALL verify: sub[2]=56'h80_0000_0000_0000, others 0 ->
- Slice 27: packet_data[7]=1.
- Slices 28..31: packet_data[3] = 1,0,0,0 and packet_data[7] = 1,0,0,1.
REQ-021 SHALL verify: start held high continuously for 3 packets -> 96 contiguous valid cycles, ready high only on slices 31, each packet's ECC matching the reference model.
REQ-022 SHALL verify: reset asserted at slice 10 -> packet_valid=0 and ready=1 immediately; the next start yields slice 0 one cycle later with correct ECC.
REQ-023 SHALL verify: start pulsed at slice 5 with different header -> ignored, output identical to the unperturbed reference packet.
